// File: rtl/color_classifier_db.sv
// RGBC colour classifier: one registered classification stage followed by a
// consecutive-sample debounce that commits a class code, one-hot flags and a change pulse.
module color_classifier_db #(
  parameter int DATA_W      = 16,
  parameter int STABLE_CNT  = 4,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] clear,
  input  logic [DATA_W-1:0] red,
  input  logic [DATA_W-1:0] green,
  input  logic [DATA_W-1:0] blue,
  input  logic [DATA_W-1:0] thr_clear,
  input  logic [DATA_W-1:0] thr_high,
  input  logic [DATA_W-1:0] thr_mid,
  output logic              is_red,
  output logic              is_green,
  output logic              is_blue,
  output logic              is_unknown,
  output logic [2:0]        class_code,
  output logic              class_chg,
  output logic              stale
);

  typedef enum logic [2:0] {
    CLS_DARK    = 3'd0,
    CLS_RED     = 3'd1,
    CLS_GREEN   = 3'd2,
    CLS_BLUE    = 3'd3,
    CLS_UNKNOWN = 3'd4
  } cls_t;

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CNT);

  // Priority order matters: a bright blue sample also passes the green test.
  function automatic cls_t classify(
    input logic [DATA_W-1:0] c, r, g, b, tc, th, tm
  );
    if (b >= th && g >= th && r < tm && c >= tc)      classify = CLS_BLUE;
    else if (g >= th && b >= tm && r < tm && c >= tc) classify = CLS_GREEN;
    else if (r >= th && g < tm && b < tm && c >= tc)  classify = CLS_RED;
    else if (c >= tm)                                 classify = CLS_UNKNOWN;
    else                                              classify = CLS_DARK;
  endfunction

  cls_t       raw_cls;
  logic       raw_vld;
  cls_t       cand, cand_nxt;
  logic [7:0] cnt, cnt_nxt;
  cls_t       code_q;
  logic       commit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_vld <= 1'b0;
      raw_cls <= CLS_DARK;
    end else begin
      raw_vld <= data_valid;
      if (data_valid)
        raw_cls <= classify(clear, red, green, blue, thr_clear, thr_high, thr_mid);
    end
  end

  always_comb begin
    cand_nxt = cand;
    cnt_nxt  = cnt;
    if (raw_vld) begin
      if (raw_cls == cand) begin
        cnt_nxt = (cnt >= STABLE_MAX) ? STABLE_MAX : cnt + 8'd1;
      end else begin
        cand_nxt = raw_cls;
        cnt_nxt  = 8'd1;
      end
    end
    commit = raw_vld && (cnt_nxt == STABLE_MAX) && (cand_nxt != code_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cand       <= CLS_DARK;
      cnt        <= 8'd0;
      code_q     <= CLS_DARK;
      class_chg  <= 1'b0;
      is_red     <= 1'b0;
      is_green   <= 1'b0;
      is_blue    <= 1'b0;
      is_unknown <= 1'b0;
    end else begin
      cand      <= cand_nxt;
      cnt       <= cnt_nxt;
      class_chg <= commit;
      if (commit) begin
        code_q     <= cand_nxt;
        is_red     <= (cand_nxt == CLS_RED);
        is_green   <= (cand_nxt == CLS_GREEN);
        is_blue    <= (cand_nxt == CLS_BLUE);
        is_unknown <= (cand_nxt == CLS_UNKNOWN);
      end
    end
  end

  assign class_code = code_q;

  generate
    if (TIMEOUT_CYC > 0) begin : g_timeout
      localparam int         IW       = $clog2(TIMEOUT_CYC + 1);
      localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYC);
      logic [IW-1:0] idle;

      // stale tracks idle == IDLE_MAX, registered alongside the counter.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          idle  <= '0;
          stale <= 1'b0;
        end else if (data_valid) begin
          idle  <= '0;
          stale <= 1'b0;
        end else if (idle != IDLE_MAX) begin
          idle  <= idle + 1'b1;
          stale <= (idle == IDLE_MAX - 1'b1);
        end
      end
    end else begin : g_no_timeout
      assign stale = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_color_classifier_db.sv
// Bench for color_classifier_db: directed scenarios plus randomized runs, with a
// history-based reference model feeding an expected-commit queue checked by a monitor.
module tb_color_classifier_db;

  localparam int DW  = 16;
  localparam int SC  = 4;
  localparam int TO  = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          data_valid;
  logic [DW-1:0] clear, red, green, blue, thr_clear, thr_high, thr_mid;
  logic          is_red, is_green, is_blue, is_unknown;
  logic [2:0]    class_code;
  logic          class_chg;
  logic          stale;

  color_classifier_db #(.DATA_W(DW), .STABLE_CNT(SC), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .data_valid(data_valid),
    .clear(clear), .red(red), .green(green), .blue(blue),
    .thr_clear(thr_clear), .thr_high(thr_high), .thr_mid(thr_mid),
    .is_red(is_red), .is_green(is_green), .is_blue(is_blue), .is_unknown(is_unknown),
    .class_code(class_code), .class_chg(class_chg), .stale(stale)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // scoreboard: each entry is {expected edge index, expected class}
  logic [34:0] exp_q[$];
  logic [2:0]  hist[$];
  logic [2:0]  m_code = 3'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] ref_class(input logic [DW-1:0] c, r, g, b, tc, th, tm);
    if (b >= th && g >= th && r < tm && c >= tc)      return 3'd3;
    else if (g >= th && b >= tm && r < tm && c >= tc) return 3'd2;
    else if (r >= th && g < tm && b < tm && c >= tc)  return 3'd1;
    else if (c >= tm)                                 return 3'd4;
    return 3'd0;
  endfunction

  function automatic logic [3:0] ref_flags(input logic [2:0] code);
    case (code)
      3'd1:    return 4'b1000;
      3'd2:    return 4'b0100;
      3'd3:    return 4'b0010;
      3'd4:    return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  // A class commits once the last SC samples all agree and differ from the committed class.
  task automatic model_sample(input logic [2:0] cls);
    logic all_same;
    hist.push_back(cls);
    if (hist.size() > SC) void'(hist.pop_front());
    all_same = (hist.size() == SC);
    foreach (hist[i]) if (hist[i] != cls) all_same = 1'b0;
    if (all_same && cls != m_code) begin
      m_code = cls;
      exp_q.push_back({cyc + 2, cls});
    end
  endtask

  // driver tasks
  task automatic send(input logic [DW-1:0] c, r, g, b, tc, th, tm);
    @(negedge clk);
    clear = c; red = r; green = g; blue = b;
    thr_clear = tc; thr_high = th; thr_mid = tm;
    data_valid = 1'b1;
    model_sample(ref_class(c, r, g, b, tc, th, tm));
    @(posedge clk);
    #1 data_valid = 1'b0;
  endtask

  task automatic send_std(input logic [DW-1:0] c, r, g, b, input int n);
    repeat (n) send(c, r, g, b, 16'h00F0, 16'h0070, 16'h0030);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string name, input logic [2:0] code);
    chk({name, "_code"}, 32'(class_code), 32'(code));
    chk({name, "_flags"}, 32'({is_red, is_green, is_blue, is_unknown}), 32'(ref_flags(code)));
  endtask

  // monitor: pops an expectation for every class_chg pulse
  initial begin
    logic [34:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (class_chg) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_chg", 32'(class_code), 32'(m_code));
            chk("unexpected_chg_pulse", 32'(class_chg), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("chg_cycle", 32'(cyc), e[34:3]);
            chk("chg_code", 32'(class_code), 32'(e[2:0]));
            chk("chg_flags", 32'({is_red, is_green, is_blue, is_unknown}), 32'(ref_flags(e[2:0])));
          end
        end else if (exp_q.size() > 0 && int'(exp_q[0][34:3]) < cyc) begin
          e = exp_q.pop_front();
          chk("missed_chg", 32'(class_chg), 32'd1);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] pc, pr, pg, pb, tc, th, tm;
    int sel;
    rst = 1'b0; data_valid = 1'b0;
    clear = '0; red = '0; green = '0; blue = '0;
    thr_clear = '0; thr_high = '0; thr_mid = '0;
    idle(3);
    check_outputs("reset", 3'd0);
    chk("reset_chg", 32'(class_chg), 32'd0);
    chk("reset_stale", 32'(stale), 32'd0);
    @(negedge clk) rst = 1'b1;

    // debounce: four RED samples commit one cycle after the 4th
    send_std(16'h0100, 16'h0090, 16'h0010, 16'h0010, 4);
    idle(1);
    check_outputs("debounce_red", 3'd1);
    chk("debounce_pulse", 32'(class_chg), 32'd1);
    send_std(16'h0100, 16'h0090, 16'h0010, 16'h0010, 1);
    idle(2);
    chk("fifth_no_pulse", 32'(class_chg), 32'd0);

    // interrupted run: only the final four REDs commit
    send_std(16'h0100, 16'h0050, 16'h0050, 16'h0050, 4);
    idle(1);
    check_outputs("unknown", 3'd4);
    send_std(16'h0100, 16'h0090, 16'h0010, 16'h0010, 3);
    send_std(16'h0100, 16'h0010, 16'h0080, 16'h0040, 1);
    send_std(16'h0100, 16'h0090, 16'h0010, 16'h0010, 3);
    idle(1);
    check_outputs("interrupted_hold", 3'd4);
    send_std(16'h0100, 16'h0090, 16'h0010, 16'h0010, 1);
    idle(1);
    check_outputs("interrupted_red", 3'd1);

    // priority: BLUE beats GREEN; lower blue falls to GREEN
    send_std(16'h0100, 16'h0010, 16'h0080, 16'h0080, 4);
    idle(1);
    check_outputs("prio_blue", 3'd3);
    send_std(16'h0100, 16'h0010, 16'h0080, 16'h0040, 4);
    idle(1);
    check_outputs("prio_green", 3'd2);

    // dark and unknown
    send_std(16'h0020, 16'h0090, 16'h0010, 16'h0010, 4);
    idle(1);
    check_outputs("dark", 3'd0);
    send_std(16'h0100, 16'h0050, 16'h0050, 16'h0050, 4);
    idle(1);
    check_outputs("unknown2", 3'd4);

    // reset mid-run with RED committed and a 3-sample partial run
    send_std(16'h0100, 16'h0090, 16'h0010, 16'h0010, 4);
    send_std(16'h0100, 16'h0010, 16'h0080, 16'h0040, 1);
    send_std(16'h0100, 16'h0090, 16'h0010, 16'h0010, 3);
    @(negedge clk) rst = 1'b0;
    #1;
    check_outputs("midrun_reset", 3'd0);
    chk("midrun_reset_chg", 32'(class_chg), 32'd0);
    chk("midrun_reset_stale", 32'(stale), 32'd0);
    hist.delete(); exp_q.delete(); m_code = 3'd0;
    @(negedge clk) rst = 1'b1;
    send_std(16'h0100, 16'h0010, 16'h0080, 16'h0080, 1);
    send_std(16'h0100, 16'h0090, 16'h0010, 16'h0010, 3);
    idle(3);
    check_outputs("post_reset_hold", 3'd0);
    send_std(16'h0100, 16'h0090, 16'h0010, 16'h0010, 1);
    idle(1);
    check_outputs("post_reset_red", 3'd1);

    // timeout: stale rises after the 10th idle edge, cleared by the next sample
    send_std(16'h0100, 16'h0090, 16'h0010, 16'h0010, 1);
    for (int i = 1; i < TO; i++) begin
      idle(1);
      chk("stale_early", 32'(stale), 32'd0);
    end
    idle(1);
    chk("stale_set", 32'(stale), 32'd1);
    chk("stale_code", 32'(class_code), 32'(m_code));
    send_std(16'h0100, 16'h0090, 16'h0010, 16'h0010, 1);
    chk("stale_clear", 32'(stale), 32'd0);
    idle(TO - 1);
    send_std(16'h0100, 16'h0090, 16'h0010, 16'h0010, 1);
    chk("stale_race", 32'(stale), 32'd0);

    // randomized runs, fixed thresholds then random thresholds
    for (int run = 0; run < 160; run++) begin
      sel = $urandom_range(0, 6);
      tc = 16'h00F0; th = 16'h0070; tm = 16'h0030;
      case (sel)
        0: begin pc = 16'h0100; pr = 16'h0090; pg = 16'h0010; pb = 16'h0010; end
        1: begin pc = 16'h0100; pr = 16'h0010; pg = 16'h0080; pb = 16'h0040; end
        2: begin pc = 16'h0100; pr = 16'h0010; pg = 16'h0080; pb = 16'h0080; end
        3: begin pc = 16'h0100; pr = 16'h0050; pg = 16'h0050; pb = 16'h0050; end
        4: begin pc = 16'h0020; pr = 16'h0090; pg = 16'h0010; pb = 16'h0010; end
        default: begin
          pc = 16'($urandom_range(0, 511)); pr = 16'($urandom_range(0, 255));
          pg = 16'($urandom_range(0, 255)); pb = 16'($urandom_range(0, 255));
          if (run >= 80) begin
            tc = 16'($urandom_range(0, 511)); th = 16'($urandom_range(0, 255));
            tm = 16'($urandom_range(0, 255));
          end
        end
      endcase
      repeat ($urandom_range(1, 6)) begin
        send(pc, pr, pg, pb, tc, th, tm);
        if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      end
    end

    idle(5);
    check_outputs("final", m_code);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
